// File: rtl/codec_i2s_rx.sv
// I2S receiver for the codec ADC path: generates bclk/lrclk and deserialises
// 24-bit MSB-first two's-complement samples into per-channel strobed words.
module codec_i2s_rx #(
    parameter int BCLK_DIV = 4
) (
    input  logic        clk,
    input  logic        rst,
    output logic        codec_bclk,
    output logic        codec_lrclk,
    input  logic        codec_sdout,
    output logic [1:0]  dout_valid,
    output logic [23:0] dout
);

    localparam logic [7:0] DIV_LAST = 8'(BCLK_DIV - 1);

    logic [7:0]  div_cnt;
    logic [5:0]  bit_cnt;
    logic [23:0] shift_reg;
    logic [1:0]  sdout_sync;
    logic        tick;
    logic        rise_evt;
    logic [4:0]  slot;
    logic        capture;
    logic [23:0] shift_next;

    assign tick        = (div_cnt == DIV_LAST);
    assign rise_evt    = tick & ~codec_bclk;
    assign slot        = bit_cnt[4:0];
    assign capture     = rise_evt && (slot >= 5'd1) && (slot <= 5'd24);
    assign shift_next  = {shift_reg[22:0], sdout_sync[1]};
    assign codec_lrclk = bit_cnt[5];

    always_ff @(posedge clk) begin
        if (rst) begin
            div_cnt    <= '0;
            bit_cnt    <= '0;
            shift_reg  <= '0;
            sdout_sync <= '0;
            codec_bclk <= 1'b0;
            dout_valid <= '0;
            dout       <= '0;
        end else begin
            sdout_sync <= {sdout_sync[0], codec_sdout};
            div_cnt    <= tick ? 8'd0 : div_cnt + 8'd1;
            dout_valid <= '0;

            if (tick) begin
                codec_bclk <= ~codec_bclk;
            end
            // bit_cnt advances on the bclk falling edge so lrclk changes with it
            if (tick && codec_bclk) begin
                bit_cnt <= bit_cnt + 6'd1;
            end

            if (capture) begin
                shift_reg <= shift_next;
                if (slot == 5'd24) begin
                    dout       <= shift_next;
                    dout_valid <= bit_cnt[5] ? 2'b10 : 2'b01;
                end
            end
        end
    end

endmodule

// File: tb/tb_codec_i2s_rx.sv
// Bench for codec_i2s_rx: an I2S codec model per instance feeds a scoreboard of
// expected words; tasks check reset, clocking, data integrity and dividers 3/4/16.
module tb_codec_i2s_rx;

    logic        clk = 1'b0;
    logic        rst;
    logic        sdout [3];
    logic        bclk  [3];
    logic        lrclk [3];
    logic [1:0]  dv    [3];
    logic [23:0] dout  [3];

    int tests  = 0;
    int failed = 0;
    int cyc    = 0;
    int rel_base = 0;

    int          mcnt     [3];
    logic        prevb    [3];
    logic        pending  [3];
    logic [23:0] cur_word [3];
    logic [23:0] tx_l = '0;
    logic [23:0] tx_r = '0;
    logic        pad0 = 1'b0;

    logic [25:0] exp_q [3][$];
    logic [25:0] rx_q  [3][$];
    int          rx_t  [3][$];

    always #5 clk = ~clk;

    codec_i2s_rx #(.BCLK_DIV(4)) u_dut0 (
        .clk(clk), .rst(rst), .codec_bclk(bclk[0]), .codec_lrclk(lrclk[0]),
        .codec_sdout(sdout[0]), .dout_valid(dv[0]), .dout(dout[0])
    );
    codec_i2s_rx #(.BCLK_DIV(3)) u_dut1 (
        .clk(clk), .rst(rst), .codec_bclk(bclk[1]), .codec_lrclk(lrclk[1]),
        .codec_sdout(sdout[1]), .dout_valid(dv[1]), .dout(dout[1])
    );
    codec_i2s_rx #(.BCLK_DIV(16)) u_dut2 (
        .clk(clk), .rst(rst), .codec_bclk(bclk[2]), .codec_lrclk(lrclk[2]),
        .codec_sdout(sdout[2]), .dout_valid(dv[2]), .dout(dout[2])
    );

    // Codec model and output collector. Data is launched just after each bclk
    // fall; the word for a channel is latched when its MSB slot starts.
    initial begin : codec_model
        int   k;
        logic ch;
        for (int i = 0; i < 3; i++) begin
            mcnt[i] = 0; prevb[i] = 1'b0; pending[i] = 1'b0;
            cur_word[i] = '0; sdout[i] = 1'b0;
        end
        forever begin
            @(posedge clk);
            #1;
            cyc++;
            for (int i = 0; i < 3; i++) begin
                if (dv[i] !== 2'b00) begin
                    rx_q[i].push_back({dv[i], dout[i]});
                    rx_t[i].push_back(cyc);
                    pending[i] = 1'b0;
                end
                if (rst) begin
                    if (pending[i]) begin
                        void'(exp_q[i].pop_back());
                        pending[i] = 1'b0;
                    end
                    mcnt[i]  = 0;
                    prevb[i] = 1'b0;
                    sdout[i] = (i == 0) ? pad0 : 1'($urandom_range(0, 1));
                end else begin
                    if (prevb[i] && !bclk[i]) begin
                        mcnt[i] = (mcnt[i] + 1) % 64;
                        k  = mcnt[i] % 32;
                        ch = (mcnt[i] >= 32);
                        if (k == 1) begin
                            if (i == 0) cur_word[i] = ch ? tx_r : tx_l;
                            else        cur_word[i] = 24'($urandom());
                            exp_q[i].push_back({(ch ? 2'b10 : 2'b01), cur_word[i]});
                            pending[i] = 1'b1;
                        end
                        if (k >= 1 && k <= 24) sdout[i] = cur_word[i][24 - k];
                        else if (i == 0)       sdout[i] = pad0;
                        else                   sdout[i] = 1'($urandom_range(0, 1));
                    end
                    prevb[i] = bclk[i];
                end
            end
        end
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic do_reset(input int n);
        @(negedge clk);
        rst = 1'b1;
        repeat (n) @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            exp_q[i].delete(); rx_q[i].delete(); rx_t[i].delete();
        end
        rst = 1'b0;
        rel_base = cyc;
    endtask

    task automatic test_reset();
        int rise1, rise2, lr1, lr2, edges, bad;
        logic pb, pl;
        rst = 1'b1;
        repeat (10) @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            tests++;
            if (bclk[i] !== 1'b0) begin failed++; $display("FAIL reset_bclk[%0d]: got %b want 0", i, bclk[i]); end
            tests++;
            if (lrclk[i] !== 1'b0) begin failed++; $display("FAIL reset_lrclk[%0d]: got %b want 0", i, lrclk[i]); end
            tests++;
            if (dv[i] !== 2'b00) begin failed++; $display("FAIL reset_valid[%0d]: got %b want 00", i, dv[i]); end
            tests++;
            if (dout[i] !== 24'h0) begin failed++; $display("FAIL reset_dout[%0d]: got %h want 000000", i, dout[i]); end
        end
        rst = 1'b0;
        rise1 = -1; rise2 = -1; lr1 = -1; lr2 = -1; edges = 0; bad = 0;
        pb = 1'b0; pl = 1'b0;
        for (int t = 1; t <= 1100; t++) begin
            @(posedge clk);
            #2;
            if (bclk[0] && !pb) begin
                if (rise1 < 0) rise1 = t;
                else if (rise2 < 0) rise2 = t;
            end
            if (lrclk[0] !== pl) begin
                edges++;
                if (!(pb && !bclk[0])) bad++;
                if (lrclk[0]) begin
                    if (lr1 < 0) lr1 = t;
                    else if (lr2 < 0) lr2 = t;
                end
            end
            pb = bclk[0];
            pl = lrclk[0];
        end
        tests++;
        if (rise1 != 4) begin failed++; $display("FAIL bclk_first_high: got cycle %0d want 4", rise1); end
        tests++;
        if (rise2 - rise1 != 8) begin failed++; $display("FAIL bclk_period: got %0d want 8", rise2 - rise1); end
        tests++;
        if (lr1 != 256) begin failed++; $display("FAIL lrclk_first_high: got cycle %0d want 256", lr1); end
        tests++;
        if (lr2 - lr1 != 512) begin failed++; $display("FAIL lrclk_period: got %0d want 512", lr2 - lr1); end
        tests++;
        if (edges != 4) begin failed++; $display("FAIL lrclk_edges: got %0d want 4", edges); end
        tests++;
        if (bad != 0) begin failed++; $display("FAIL lrclk_vs_bclk_fall: got %0d misaligned want 0", bad); end
    endtask

    task automatic test_left_impulse();
        int n, t0, t1;
        logic [25:0] got, want;
        tx_l = 24'h400000; tx_r = 24'h000000; pad0 = 1'b0;
        do_reset(3);
        n = 0;
        while (rx_q[0].size() < 2 && n < 2000) begin @(posedge clk); #2; n++; end
        tests++;
        if (rx_q[0].size() < 2) begin
            failed++; $display("FAIL impulse_timeout: got %0d strobes want 2", rx_q[0].size());
        end else begin
            t0 = rx_t[0].pop_front();
            t1 = rx_t[0].pop_front();
            for (int j = 0; j < 2; j++) begin
                got  = rx_q[0].pop_front();
                want = exp_q[0].pop_front();
                tests++;
                if (got !== want) begin failed++; $display("FAIL impulse_word%0d: got %h want %h", j, got, want); end
            end
            tests++;
            if (t0 - rel_base != 196) begin failed++; $display("FAIL impulse_latency: got cycle %0d want 196", t0 - rel_base); end
            tests++;
            if (t1 - t0 != 256) begin failed++; $display("FAIL strobe_spacing: got %0d want 256", t1 - t0); end
        end
    endtask

    task automatic test_ignored_slots();
        int n;
        logic [25:0] got, want;
        tx_l = 24'h000000; tx_r = 24'h000000; pad0 = 1'b1;
        do_reset(3);
        n = 0;
        while (rx_q[0].size() < 2 && n < 2000) begin @(posedge clk); #2; n++; end
        tests++;
        if (rx_q[0].size() < 2) begin
            failed++; $display("FAIL ignored_timeout: got %0d strobes want 2", rx_q[0].size());
        end else begin
            void'(rx_t[0].pop_front()); void'(rx_t[0].pop_front());
            for (int j = 0; j < 2; j++) begin
                got  = rx_q[0].pop_front();
                want = exp_q[0].pop_front();
                tests++;
                if (got !== want) begin failed++; $display("FAIL ignored_word%0d: got %h want %h", j, got, want); end
            end
        end
        pad0 = 1'b0;
    endtask

    task automatic test_full_scale();
        int n;
        logic [25:0] got, want;
        tx_l = 24'h7FFFFF; tx_r = 24'h800001; pad0 = 1'b0;
        do_reset(3);
        n = 0;
        while (rx_q[0].size() < 2 && n < 2000) begin @(posedge clk); #2; n++; end
        tests++;
        if (rx_q[0].size() < 2) begin
            failed++; $display("FAIL fullscale_timeout: got %0d strobes want 2", rx_q[0].size());
        end else begin
            void'(rx_t[0].pop_front()); void'(rx_t[0].pop_front());
            for (int j = 0; j < 2; j++) begin
                got  = rx_q[0].pop_front();
                want = exp_q[0].pop_front();
                tests++;
                if (got !== want) begin failed++; $display("FAIL fullscale_word%0d: got %h want %h", j, got, want); end
            end
        end
    endtask

    // Runs straight on from the previous test so dout is non-zero before the pulse.
    task automatic test_reset_mid_word();
        int n, t0;
        logic [25:0] got, want;
        tx_l = 24'hABCDEF; tx_r = 24'h000000;
        n = 0;
        while (mcnt[0] != 12 && n < 1000) begin @(negedge clk); n++; end
        tests++;
        if (mcnt[0] != 12) begin
            failed++; $display("FAIL midreset_slot_timeout: got slot %0d want 12", mcnt[0]);
        end else begin
            rst = 1'b1;
            @(negedge clk);
            tx_l = 24'h123456;
            tests++;
            if (bclk[0] !== 1'b0) begin failed++; $display("FAIL midreset_bclk: got %b want 0", bclk[0]); end
            tests++;
            if (lrclk[0] !== 1'b0) begin failed++; $display("FAIL midreset_lrclk: got %b want 0", lrclk[0]); end
            tests++;
            if (dv[0] !== 2'b00) begin failed++; $display("FAIL midreset_valid: got %b want 00", dv[0]); end
            tests++;
            if (dout[0] !== 24'h0) begin failed++; $display("FAIL midreset_dout: got %h want 000000", dout[0]); end
            rst = 1'b0;
            rel_base = cyc;
            n = 0;
            while (rx_q[0].size() < 2 && n < 2000) begin @(posedge clk); #2; n++; end
            tests++;
            if (rx_q[0].size() < 2) begin
                failed++; $display("FAIL midreset_timeout: got %0d strobes want 2", rx_q[0].size());
            end else begin
                t0 = rx_t[0].pop_front();
                void'(rx_t[0].pop_front());
                tests++;
                if (t0 - rel_base != 196) begin failed++; $display("FAIL midreset_first_strobe: got cycle %0d want 196", t0 - rel_base); end
                for (int j = 0; j < 2; j++) begin
                    got  = rx_q[0].pop_front();
                    want = (exp_q[0].size() > 0) ? exp_q[0].pop_front() : 26'h3FFFFFF;
                    tests++;
                    if (got !== want) begin failed++; $display("FAIL midreset_word%0d: got %h want %h", j, got, want); end
                end
            end
        end
    endtask

    task automatic test_param_sweep();
        logic [25:0] got, want;
        int div [3];
        div[0] = 4; div[1] = 3; div[2] = 16;
        do_reset(3);
        for (int t = 1; t <= 20 * 2048 + 8; t++) begin
            @(posedge clk);
            #2;
            if (t == 50 * 384 + 8) begin
                tests++;
                if (rx_q[1].size() != 100) begin failed++; $display("FAIL sweep_count[div=3]: got %0d want 100", rx_q[1].size()); end
            end
        end
        tests++;
        if (rx_q[2].size() != 40) begin failed++; $display("FAIL sweep_count[div=16]: got %0d want 40", rx_q[2].size()); end
        for (int i = 1; i < 3; i++) begin
            while (rx_q[i].size() > 0) begin
                got = rx_q[i].pop_front();
                tests++;
                if (exp_q[i].size() == 0) begin
                    failed++; $display("FAIL sweep_unexpected[div=%0d]: got %h want none", div[i], got);
                end else begin
                    want = exp_q[i].pop_front();
                    if (got !== want) begin failed++; $display("FAIL sweep_word[div=%0d]: got %h want %h", div[i], got, want); end
                end
            end
        end
    endtask

    initial begin : main
        rst = 1'b1;
        test_reset();
        test_left_impulse();
        test_ignored_slots();
        test_full_scale();
        test_reset_mid_word();
        test_param_sweep();
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule

// File: doc/codec_i2s_rx.md
# codec_i2s_rx

Audio codec receive interface: generates the I2S bit clock and word clock for the ADC side of the codec and deserialises the serial sample stream into 24-bit two's-complement words. It sits directly upstream of the FIR filter. Its `dout`/`dout_valid` outputs drive the filter's `din`/`din_valid` unmodified: one-cycle per-channel strobes with the word held stable between strobes.

## Interface

Parameters
- `BCLK_DIV`, default 4: `clk` cycles per bit-clock half-period. Legal range is 3..255.

Ports
- `clk` in 1: system clock. All logic is on the rising edge.
- `rst` in 1: synchronous, active-high reset.
- `codec_bclk` out 1: I2S bit clock. Period is 2·`BCLK_DIV` `clk` cycles.
- `codec_lrclk` out 1: I2S word clock. 0 = left, 1 = right. Period is 64 bit-clocks.
- `codec_sdout` in 1: serial data from the codec ADC. Asynchronous to `clk`.
- `dout_valid` out 2: one-cycle strobe. Bit 0 = left word valid, bit 1 = right word valid. The two bits are never high together.
- `dout` out 24: last received sample, MSB first, two's complement.

## Operation

Reset values
- All outputs go to 0: `codec_bclk`, `codec_lrclk`, `dout_valid`, `dout`.
- Internal state goes to 0: `div_cnt`, `bit_cnt`, shift register, synchroniser.

Clock generation
- `div_cnt` counts 0..`BCLK_DIV`-1 and wraps.
- `codec_bclk` toggles on the cycle where `div_cnt`==`BCLK_DIV`-1.
- "Rise event" = that toggle cycle with `codec_bclk`==0.
- "Fall event" = that toggle cycle with `codec_bclk`==1.
- `bit_cnt` is 6 bits. It increments on each fall event and wraps 63→0.
- `codec_lrclk` = `bit_cnt[5]`, so it changes in the same cycle as the bclk falling edge.
- Slot index `k` = `bit_cnt[4:0]`.

Data capture
- `codec_sdout` passes through a 2-FF synchroniser. All sampling uses the synchroniser output.
- On a rise event with `k` in 1..24, the bit is shifted into a 24-bit register, LSB-in, MSB first.
- Slot 0 is the I2S one-bit delay and is ignored.
- Slots 25..31 are ignored.
- On the rise event of slot 24, the cycle after is output:
  - `dout` ← the completed word (current shift value with the new bit appended).
  - `dout_valid` ← 01 when `codec_lrclk`==0, 10 when `codec_lrclk`==1.
- `dout_valid` returns to 00 the following cycle. `dout` holds until the next word.

Boundary conditions
- Reset mid-frame: the partial word is discarded and no strobe is issued. Clocks restart from bit 0, left channel.
- First frame after reset: slot 0 of left is the first bclk rise, so the first left word is valid and complete.
- `codec_sdout` toggling during ignored slots has no effect on `dout`.

## Timing

- With `BCLK_DIV`=4:
  - bclk period = 8 `clk`.
  - Frame = 512 `clk`.
  - At 100 MHz `clk`, the frame rate is 195.3 kHz.
- After `rst` deasserts at cycle 0:
  - The first bclk rise event occurs at cycle `BCLK_DIV`-1.
  - `codec_bclk` is high from cycle `BCLK_DIV`.
- Strobe spacing: left and right strobes are exactly 32 bit-clocks apart (256 `clk` at default).
- A sample launched by the codec on a bclk fall is captured at the next rise event. The synchroniser costs 2 `clk`; `BCLK_DIV`≥3 keeps capture after the data has settled.
- Latency: the LSB rise event is followed one `clk` later by `dout`/`dout_valid`. `dout` changes in the same cycle as the strobe rises.

## Test plan

1. Reset value check:
   - Stimulus: hold `rst` for 10 cycles.
   - Required: all outputs are 0.
   - Then release `rst` and check `codec_bclk` period = 8 `clk` and `codec_lrclk` period = 512 `clk`.
   - Check `codec_lrclk` edges coincide with `codec_bclk` falling edges.
2. Left impulse:
   - Stimulus: a bench I2S model drives 0x400000 in the left slot and 0 in the right slot.
   - Required: `dout`=0x400000 with `dout_valid`=01 for one cycle, then `dout`=0x000000 with `dout_valid`=10, 256 cycles later.
3. Right, full-scale negative:
   - Stimulus: right word 0x800001, left word 0x7FFFFF.
   - Required: strobes with exactly those values, MSB order preserved, no sign or bit-shift error.
4. Ignored slots:
   - Stimulus: drive 1 in slot 0 and in slots 25..31 of both channels, with data word 0x000000.
   - Required: `dout`=0x000000 on both strobes.
5. Reset mid-word:
   - Stimulus: assert `rst` for 1 cycle at slot 12 of the left word.
   - Required: no strobe for that word, clocks back at the reset state next cycle.
   - Then the next full left word (0x123456) is received correctly.
6. Parameter sweep:
   - Stimulus: `BCLK_DIV`=3 and `BCLK_DIV`=16 with random words over 50 frames.
   - Required: every received word matches the transmitted word, and the strobe count equals 2 per frame.
